chunked_addsub: RTL and testbench

- Parametrised multi-cycle add/subtract unit; successor to the fixed 4-bit ripple adder.
- Latches two WIDTH-bit operands on start and processes CHUNK bits per cycle, LSB chunk first, with a registered carry between chunks.
- Reports sum, carry-out and signed overflow with a start/busy/done handshake.
- Used where a wide add must not form one long combinational carry chain.

---
 rtl/chunked_addsub_pkg.sv | 20 ++
 rtl/chunked_addsub_chunk_adder.sv | 30 +++
 rtl/chunked_addsub.sv | 125 ++++++++++++
 tb/tb_chunked_addsub.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/chunked_addsub_pkg.sv
// rtl/chunked_addsub_pkg.sv - shared state type and sizing helpers for chunked_addsub
package chunked_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of chunk steps needed to cover the full operand width.
  function automatic int calc_nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Chunk index width; never narrower than one bit so a single-chunk build still has a counter.
  function automatic int calc_idx_width(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/chunked_addsub_chunk_adder.sv
// rtl/chunked_addsub_chunk_adder.sv - combinational CHUNK-bit ripple adder from half-adder pairs
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  logic [CHUNK:0] c;

  assign c[0] = ci;

  // Each bit: first half adder combines x and y, second folds in the ripple carry.
  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    logic ha_s;
    logic ha_c;
    logic hb_c;
    assign ha_s     = x[i] ^ y[i];
    assign ha_c     = x[i] & y[i];
    assign s[i]     = ha_s ^ c[i];
    assign hb_c     = ha_s & c[i];
    assign c[i + 1] = ha_c | hb_c;
  end

  assign co = c[CHUNK];

endmodule

// File: rtl/chunked_addsub.sv
// rtl/chunked_addsub.sv - multi-cycle add/subtract processing CHUNK bits per cycle
module chunked_addsub
  import chunked_addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
  localparam int IDXW   = calc_idx_width(NCHUNK);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("chunked_addsub: WIDTH must be a positive multiple of CHUNK");
  end

  state_t state;
  state_t state_next;

  // Operands are shifted right one chunk per RUN cycle, so the active chunk is always the low bits.
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             a_msb;
  logic             b_msb;
  logic             carry;
  logic [IDXW-1:0]  idx;
  logic [WIDTH-1:0] acc;

  logic [CHUNK-1:0]       chunk_s;
  logic                   chunk_co;
  logic                   last_chunk;
  logic                   load;
  logic [WIDTH-1:0]       b_eff;
  logic [WIDTH+CHUNK-1:0] acc_cat;
  logic [WIDTH-1:0]       acc_next;

  chunk_adder #(
    .CHUNK(CHUNK)
  ) u_chunk_adder (
    .x (a_sh[CHUNK-1:0]),
    .y (b_sh[CHUNK-1:0]),
    .ci(carry),
    .s (chunk_s),
    .co(chunk_co)
  );

  assign last_chunk = (idx == LAST_IDX);
  assign load       = start && (state != RUN);
  assign b_eff      = sub ? ~b : b;

  // New chunk bits enter at the top of the accumulator; after NCHUNK steps chunk 0 sits at the bottom.
  assign acc_cat  = {chunk_s, acc};
  assign acc_next = acc_cat[WIDTH+CHUNK-1:CHUNK];

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: start is honoured only outside RUN.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_chunk) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, per-chunk add, and result publish on the final chunk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      carry <= 1'b0;
      idx   <= '0;
      acc   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (load) begin
      a_sh  <= a;
      b_sh  <= b_eff;
      a_msb <= a[WIDTH-1];
      b_msb <= b_eff[WIDTH-1];
      carry <= sub ? ~cin : cin;
      idx   <= '0;
    end else if (state == RUN) begin
      a_sh  <= a_sh >> CHUNK;
      b_sh  <= b_sh >> CHUNK;
      carry <= chunk_co;
      idx   <= idx + IDXW'(1);
      acc   <= acc_next;
      if (last_chunk) begin
        sum  <= acc_next;
        cout <= chunk_co;
        ovf  <= (a_msb == b_msb) && (chunk_s[CHUNK-1] != a_msb);
      end
    end
  end

endmodule

// File: tb/tb_chunked_addsub.sv
// tb/tb_chunked_addsub.sv - self-checking bench for chunked_addsub at CHUNK 4, 16 and 1
module tb_chunked_addsub;

  logic        clk;
  logic        rst_n;
  logic [2:0]  start_v;
  logic        sub;
  logic        cin;
  logic [15:0] a;
  logic [15:0] b;

  logic        busy0, busy1, busy2;
  logic        done0, done1, done2;
  logic [15:0] sum0, sum1, sum2;
  logic        cout0, cout1, cout2;
  logic        ovf0, ovf1, ovf2;

  int n_pass;
  int n_total;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  typedef struct {
    logic        sub_op;
    logic        cin_in;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic [15:0] exp_sum;
    logic        exp_cout;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[7];

  chunked_addsub #(.WIDTH(16), .CHUNK(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .sub(sub), .cin(cin), .a(a), .b(b),
    .busy(busy0), .done(done0), .sum(sum0), .cout(cout0), .ovf(ovf0)
  );

  chunked_addsub #(.WIDTH(16), .CHUNK(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .sub(sub), .cin(cin), .a(a), .b(b),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  chunked_addsub #(.WIDTH(16), .CHUNK(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .sub(sub), .cin(cin), .a(a), .b(b),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int nchunk_of(input int d);
    case (d)
      0:       return 4;
      1:       return 1;
      default: return 16;
    endcase
  endfunction

  function automatic logic done_of(input int d);
    case (d)
      0:       return done0;
      1:       return done1;
      default: return done2;
    endcase
  endfunction

  function automatic logic busy_of(input int d);
    case (d)
      0:       return busy0;
      1:       return busy1;
      default: return busy2;
    endcase
  endfunction

  function automatic res_t result_of(input int d);
    res_t r;
    case (d)
      0:       r = '{sum: sum0, cout: cout0, ovf: ovf0};
      1:       r = '{sum: sum1, cout: cout1, ovf: ovf1};
      default: r = '{sum: sum2, cout: cout2, ovf: ovf2};
    endcase
    return r;
  endfunction

  // Reference: plain integer arithmetic, unsigned for carry/borrow, signed for overflow.
  function automatic res_t model(input logic s, input logic c, input logic [15:0] x, input logic [15:0] y);
    res_t m;
    int ur;
    int sr;
    int sx;
    int sy;
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (!s) begin
      ur = int'(x) + int'(y) + int'(c);
      sr = sx + sy + int'(c);
      m.cout = (ur > 65535);
    end else begin
      ur = int'(x) - int'(y) - int'(c);
      sr = sx - sy - int'(c);
      m.cout = (ur >= 0);
    end
    m.sum = ur[15:0];
    m.ovf = (sr > 32767) || (sr < -32768);
    return m;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Issues one operation on DUT d; returns at the negedge of the done cycle (or on timeout).
  task automatic do_op(input int d, input logic s, input logic c, input logic [15:0] x,
                       input logic [15:0] y, output int lat, output int busy_cnt);
    @(negedge clk);
    sub = s; cin = c; a = x; b = y;
    start_v[d] = 1'b1;
    @(negedge clk);
    start_v[d] = 1'b0;
    sub = ~s; cin = ~c; a = ~x; b = y ^ 16'h5A5A;
    lat = 1;
    busy_cnt = 0;
    while (!done_of(d) && lat < 100) begin
      if (busy_of(d)) busy_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int   lat;
    int   bc;
    int   k;
    logic stable;
    logic saw_done;
    res_t r;
    res_t e;
    logic [15:0] rx;
    logic [15:0] ry;
    logic rs;
    logic rc;

    n_pass = 0;
    n_total = 0;
    start_v = 3'b000;
    sub = 1'b0; cin = 1'b0; a = '0; b = '0;

    vecs[0] = '{1'b0, 1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 16'h0010, 16'h0003, 16'h000C, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 16'h8000, 16'h8000, 16'h0001, 1'b1, 1'b1};

    rst_n = 1'b0;
    #2;
    check("reset_busy", {31'd0, busy0}, 32'd0);
    check("reset_done", {31'd0, done0}, 32'd0);
    check("reset_sum", {16'd0, sum0}, 32'd0);
    check("reset_cout_ovf", {30'd0, cout0, ovf0}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors on the CHUNK=4 unit.
    for (int i = 0; i < 7; i++) begin
      do_op(0, vecs[i].sub_op, vecs[i].cin_in, vecs[i].a_in, vecs[i].b_in, lat, bc);
      r = result_of(0);
      check($sformatf("vec%0d_sum", i), {16'd0, r.sum}, {16'd0, vecs[i].exp_sum});
      check($sformatf("vec%0d_cout", i), {31'd0, r.cout}, {31'd0, vecs[i].exp_cout});
      check($sformatf("vec%0d_ovf", i), {31'd0, r.ovf}, {31'd0, vecs[i].exp_ovf});
      check($sformatf("vec%0d_latency", i), lat, 5);
      check($sformatf("vec%0d_busy_cycles", i), bc, 4);
      @(negedge clk);
      check($sformatf("vec%0d_done_pulse", i), {31'd0, done0}, 32'd0);
      check($sformatf("vec%0d_sum_idle", i), {16'd0, sum0}, {16'd0, vecs[i].exp_sum});
    end

    // start asserted with new operands during RUN must be ignored.
    @(negedge clk);
    sub = 1'b0; cin = 1'b0; a = 16'h1111; b = 16'h2222;
    start_v[0] = 1'b1;
    @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start_v[0] = 1'b0;
    k = 3;
    while (!done0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("run_start_ignored_sum", {16'd0, sum0}, 32'h3333);
    check("run_start_ignored_latency", k, 5);

    // Back-to-back: start held in the DONE cycle.
    do_op(0, 1'b0, 1'b0, 16'h0100, 16'h0001, lat, bc);
    check("b2b_first_sum", {16'd0, sum0}, 32'h0101);
    sub = 1'b0; cin = 1'b0; a = 16'h0002; b = 16'h0003;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    check("b2b_busy", {31'd0, busy0}, 32'd1);
    k = 1;
    stable = 1'b1;
    while (!done0 && k < 100) begin
      if (sum0 !== 16'h0101) stable = 1'b0;
      @(negedge clk);
      k++;
    end
    check("b2b_interval", k, 5);
    check("b2b_sum_stable", {31'd0, stable}, 32'd1);
    check("b2b_second_sum", {16'd0, sum0}, 32'h0005);

    // Asynchronous reset in the second RUN cycle.
    @(negedge clk);
    a = 16'h1000; b = 16'h2000; sub = 1'b0; cin = 1'b1;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    @(negedge clk);
    check("pre_reset_busy", {31'd0, busy0}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy0}, 32'd0);
    check("abort_done", {31'd0, done0}, 32'd0);
    check("abort_sum", {16'd0, sum0}, 32'd0);
    check("abort_cout_ovf", {30'd0, cout0, ovf0}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done0 || busy0) saw_done = 1'b1;
    end
    check("abort_no_done", {31'd0, saw_done}, 32'd0);
    do_op(0, 1'b0, 1'b0, 16'h00FF, 16'h0001, lat, bc);
    check("post_reset_sum", {16'd0, sum0}, 32'h0100);
    check("post_reset_latency", lat, 5);

    // Random operands on all three chunk sizes against the reference model.
    for (int d = 0; d < 3; d++) begin
      for (int n = 0; n < 30; n++) begin
        rx = 16'($urandom);
        ry = 16'($urandom);
        if (n == 0) begin rx = 16'hFFFF; ry = 16'hFFFF; end
        if (n == 1) begin rx = 16'h8000; ry = 16'h7FFF; end
        rs = 1'($urandom_range(0, 1));
        rc = 1'($urandom_range(0, 1));
        e = model(rs, rc, rx, ry);
        do_op(d, rs, rc, rx, ry, lat, bc);
        r = result_of(d);
        check($sformatf("rand_d%0d_n%0d_sum", d, n), {16'd0, r.sum}, {16'd0, e.sum});
        check($sformatf("rand_d%0d_n%0d_flags", d, n), {30'd0, r.cout, r.ovf}, {30'd0, e.cout, e.ovf});
        check($sformatf("rand_d%0d_n%0d_latency", d, n), lat, nchunk_of(d) + 1);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
